mux_nto1_pipe: RTL

//  Parametrised N-input, WIDTH-bit selector with a registered output stage and valid/ready handshake.

---
 rtl/mux_nto1_pipe_pkg.sv | 17 +
 rtl/mux_nto1_comb.sv | 27 ++
 rtl/mux_nto1_pipe.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mux_nto1_pipe_pkg.sv
// Shared defaults, zero-fill value and entry-state encoding for mux_nto1_pipe.
// The state TWO is only reachable when MUX_NTO1_PIPE_SKID_EN is defined.
package mux_nto1_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_N_IN  = 4;
  localparam int unsigned DEF_SEL_W = 2;

  localparam logic ZERO_FILL_BIT = 1'b0;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } ent_state_e;

endpackage

// File: rtl/mux_nto1_comb.sv
// Combinational N-way channel select.
// An out-of-range select yields all-zero data and raises oor_o.
module mux_nto1_comb
  import mux_nto1_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      sel_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  oor_o
);

  always_comb begin
    data_o = {WIDTH{ZERO_FILL_BIT}};
    oor_o  = 1'b1;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = data_i[k*WIDTH +: WIDTH];
        oor_o  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 selector with valid/ready handshake and synchronous flush.
// Define MUX_NTO1_PIPE_SKID_EN for a 2-entry skid buffer with registered ready_o.
module mux_nto1_pipe
  import mux_nto1_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_IN  = DEF_N_IN,
  parameter int unsigned SEL_W = DEF_SEL_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]      select_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  sel_err_o
);

  logic [WIDTH-1:0] sel_data;
  logic             sel_oor;
  logic             in_xfer;
  logic             out_xfer;

  ent_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             err_q, err_d;
`ifdef MUX_NTO1_PIPE_SKID_EN
  logic [WIDTH-1:0] skid_q, skid_d;
`endif

  mux_nto1_comb #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_comb (
    .data_i (data_i),
    .sel_i  (select_i),
    .data_o (sel_data),
    .oor_o  (sel_oor)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef MUX_NTO1_PIPE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      err_q   <= err_d;
`ifdef MUX_NTO1_PIPE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    err_d   = err_q || (in_xfer && sel_oor);
`ifdef MUX_NTO1_PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            data_d  = sel_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            data_d = sel_data;
          end else if (out_xfer) begin
            state_d = EMPTY;
`ifdef MUX_NTO1_PIPE_SKID_EN
          end else if (in_xfer) begin
            state_d = TWO;
            skid_d  = sel_data;
`endif
          end
        end
`ifdef MUX_NTO1_PIPE_SKID_EN
        // ready_o is low in TWO, so only a drain can happen: skid moves to main.
        TWO: begin
          if (out_xfer) begin
            state_d = ONE;
            data_d  = skid_q;
          end
        end
`endif
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_o   = (state_q != EMPTY);
    data_o    = data_q;
    sel_err_o = err_q;
`ifdef MUX_NTO1_PIPE_SKID_EN
    ready_o   = (state_q != TWO);
`else
    ready_o   = (state_q == EMPTY) || ready_i;
`endif
  end

endmodule
